uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter merging byte-stream messages into one UART byte stream
// A grant is held for a whole message; a one-byte output register decouples the source from the pipeline.
module uart_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_48mhz,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [7:0]             uart_in_data,
    output logic                   uart_in_valid,
    input  logic                   uart_in_ready,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   timeout_pulse
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]      STALL_MAX = CW'(TIMEOUT - 1);
    localparam logic [2:0]         LAST_IDX  = 3'(NUM_SRC - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0  = NUM_SRC'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           rr_ptr;
    logic [CW-1:0]        stall_cnt;
    logic [NUM_SRC-1:0]   valid_shift;
    logic [NUM_SRC-1:0]   last_shift;
    logic [8*NUM_SRC-1:0] data_shift;
    logic                 cur_valid;
    logic                 cur_last;
    logic [7:0]           cur_data;
    logic                 take;
    logic                 up_xfer;
    logic                 msg_done;
    logic                 stall_expire;
    logic                 req_found;
    logic [2:0]           req_idx;
    logic [2:0]           next_ptr;
    logic [NUM_SRC-1:0]   probe_valid;
    int                   probe;

    assign valid_shift = src_valid >> grant_id;
    assign last_shift  = src_last >> grant_id;
    assign data_shift  = src_data >> {grant_id, 3'b000};
    assign cur_valid   = valid_shift[0];
    assign cur_last    = last_shift[0];
    assign cur_data    = data_shift[7:0];

    // Granted source may push whenever the output register is empty or draining this cycle.
    assign take         = (state == BUSY) && (!uart_in_valid || uart_in_ready);
    assign up_xfer      = take && cur_valid;
    assign msg_done     = up_xfer && cur_last;
    assign stall_expire = (state == BUSY) && !cur_valid && (stall_cnt == STALL_MAX);
    assign next_ptr     = (grant_id == LAST_IDX) ? 3'd0 : grant_id + 3'd1;

    always_comb begin
        req_found   = 1'b0;
        req_idx     = 3'd0;
        probe       = 0;
        probe_valid = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            probe       = (int'(rr_ptr) + k) % NUM_SRC;
            probe_valid = src_valid >> probe;
            if (!req_found && probe_valid[0]) begin
                req_found = 1'b1;
                req_idx   = 3'(probe);
            end
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable && req_found)     state_next = BUSY;
            BUSY: if (msg_done || stall_expire) state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BUSY);
        src_ready = take ? (ONE_HOT0 << grant_id) : '0;
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            rr_ptr        <= 3'd0;
            grant_id      <= 3'd0;
            stall_cnt     <= '0;
            uart_in_valid <= 1'b0;
            uart_in_data  <= 8'h00;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= stall_expire;
            if (state == IDLE && enable && req_found) begin
                grant_id  <= req_idx;
                stall_cnt <= '0;
            end
            if (state == BUSY) begin
                // Only a missing source byte counts as a stall; downstream backpressure does not.
                if (up_xfer)
                    stall_cnt <= '0;
                else if (!cur_valid)
                    stall_cnt <= stall_expire ? '0 : stall_cnt + 1'b1;
                if (msg_done || stall_expire)
                    rr_ptr <= next_ptr;
            end
            if (up_xfer) begin
                uart_in_data  <= cur_data;
                uart_in_valid <= 1'b1;
            end else if (uart_in_valid && uart_in_ready) begin
                uart_in_valid <= 1'b0;
            end
        end
    end

endmodule
